// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel sensor alarm.
//   ch_state_e : per-channel alarm FSM state
//   cnt_width  : width of a counter that must hold values 0..x-1 (never below 1 bit)
package alarm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StAlarm,
    StHold,
    StSilenced
  } ch_state_e;

  function automatic int unsigned cnt_width(input int unsigned x);
    int unsigned w;
    w = $clog2(x);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_sensor_alarm_if.sv
// Sensor/buzzer bundle for multi_sensor_alarm.
//   master : controller side (drives enable, pulse_mode, sensor, ack; observes status)
//   slave  : alarm block side (samples controls, drives buzzer and status)
interface multi_sensor_alarm_if
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_CH = 3
);

  localparam int unsigned CntW = cnt_width(NUM_CH + 1);

  logic              enable;
  logic              pulse_mode;
  logic [NUM_CH-1:0] sensor;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] buzzer;
  logic [NUM_CH-1:0] alarm_active;
  logic              any_alarm;
  logic [CntW-1:0]   alarm_count;

  modport master (
    output enable, pulse_mode, sensor, ack,
    input  buzzer, alarm_active, any_alarm, alarm_count
  );

  modport slave (
    input  enable, pulse_mode, sensor, ack,
    output buzzer, alarm_active, any_alarm, alarm_count
  );

endinterface

// File: rtl/alarm_channel.sv
// One sensor/buzzer channel: debounce, alarm with optional beep pattern, post-release hold,
// and acknowledge/silence.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   enable_i       : 0 forces the channel to idle at the next edge
//   pulse_mode_i   : 0 = continuous buzzer, 1 = beep pattern
//   sensor_i/ack_i : channel sensor input and acknowledge request
//   buzzer_o       : registered buzzer drive
//   active_o       : registered, 1 while in alarm or hold
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BEEP_HALF       = 2,
  parameter int unsigned HOLD_CYCLES     = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic pulse_mode_i,
  input  logic sensor_i,
  input  logic ack_i,
  output logic buzzer_o,
  output logic active_o
);

  localparam int unsigned DebW  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned BeepW = cnt_width(BEEP_HALF);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BeepW-1:0] BeepLast = BeepW'(BEEP_HALF - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  ch_state_e        state_q, state_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [BeepW-1:0] beep_cnt_q, beep_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             phase_q, phase_d;
  logic             buzzer_q, buzzer_d;
  logic             active_q, active_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      deb_cnt_q  <= '0;
      beep_cnt_q <= '0;
      hold_cnt_q <= '0;
      phase_q    <= 1'b0;
      buzzer_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      beep_cnt_q <= beep_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      phase_q    <= phase_d;
      buzzer_q   <= buzzer_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    beep_cnt_d = beep_cnt_q;
    hold_cnt_d = hold_cnt_q;
    phase_d    = phase_q;

    // The beep pattern free-runs through alarm and hold so a re-trigger does not restart it.
    if ((state_q == StAlarm) || (state_q == StHold)) begin
      if (beep_cnt_q == BeepLast) begin
        beep_cnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        beep_cnt_d = beep_cnt_q + BeepW'(1);
      end
    end

    if (!enable_i) begin
      state_d    = StIdle;
      deb_cnt_d  = '0;
      beep_cnt_d = '0;
      hold_cnt_d = '0;
      phase_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sensor_i) begin
            state_d   = StDebounce;
            deb_cnt_d = '0;
          end
        end
        StDebounce: begin
          if (!sensor_i) begin
            state_d = StIdle;
          end else if (deb_cnt_q == DebLast) begin
            state_d    = StAlarm;
            beep_cnt_d = '0;
            phase_d    = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
          end
        end
        StAlarm: begin
          if (ack_i) begin
            state_d = StSilenced;
          end else if (!sensor_i) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end
        end
        StHold: begin
          if (ack_i) begin
            state_d = StIdle;
          end else if (sensor_i) begin
            state_d = StAlarm;
          end else if (hold_cnt_q == HoldLast) begin
            state_d = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        StSilenced: begin
          if (!sensor_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    active_d = (state_d == StAlarm) || (state_d == StHold);
    buzzer_d = active_d & (pulse_mode_i ? phase_d : 1'b1);
  end

  assign buzzer_o = buzzer_q;
  assign active_o = active_q;

endmodule

// File: rtl/multi_sensor_alarm.sv
// N-channel sensor alarm: one independent alarm_channel per sensor/buzzer pair, plus
// aggregate status for a status LED (any_alarm) and a count display (alarm_count).
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : sensor/buzzer bundle (slave side)
module multi_sensor_alarm
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_CH          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BEEP_HALF       = 2,
  parameter int unsigned HOLD_CYCLES     = 8
) (
  input  logic                clk,
  input  logic                reset,
  multi_sensor_alarm_if.slave bus
);

  localparam int unsigned CntW = cnt_width(NUM_CH + 1);

  logic [NUM_CH-1:0] buzzer_w;
  logic [NUM_CH-1:0] active_w;
  logic [CntW-1:0]   count_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alarm_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BEEP_HALF      (BEEP_HALF),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (reset),
      .enable_i    (bus.enable),
      .pulse_mode_i(bus.pulse_mode),
      .sensor_i    (bus.sensor[i]),
      .ack_i       (bus.ack[i]),
      .buzzer_o    (buzzer_w[i]),
      .active_o    (active_w[i])
    );
  end

  always_comb begin
    count_w = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      count_w = count_w + CntW'(active_w[i]);
    end
  end

  assign bus.buzzer       = buzzer_w;
  assign bus.alarm_active = active_w;
  assign bus.any_alarm    = |active_w;
  assign bus.alarm_count  = count_w;

endmodule

// File: tb/tb_multi_sensor_alarm.sv
// Directed self-checking bench for multi_sensor_alarm with default parameters.
module tb_multi_sensor_alarm;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  multi_sensor_alarm_if #(.NUM_CH(3)) bus ();

  multi_sensor_alarm #(
    .NUM_CH         (3),
    .DEBOUNCE_CYCLES(4),
    .BEEP_HALF      (2),
    .HOLD_CYCLES    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs set before the call are sampled at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.sensor = 3'b000;
    bus.ack    = 3'b000;
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.pulse_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sensor = 3'($urandom);
      bus.ack    = 3'($urandom);
      step();
      if (bus.buzzer !== 3'b000) begin
        $display("FAIL reset_buzzer: got %b want 000", bus.buzzer); n_fail++;
      end
      n_checks++;
      if (bus.alarm_active !== 3'b000 || bus.alarm_count !== 2'd0 || bus.any_alarm !== 1'b0) begin
        $display("FAIL reset_status: active %b count %0d any %b want 000/0/0",
                 bus.alarm_active, bus.alarm_count, bus.any_alarm); n_fail++;
      end
      n_checks++;
    end
    bus.sensor = 3'b000;
    bus.ack    = 3'b000;
    reset      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.buzzer !== 3'b000 || bus.alarm_count !== 2'd0) begin
        $display("FAIL post_reset_idle: buzzer %b count %0d want 000/0",
                 bus.buzzer, bus.alarm_count); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_glitch();
    bus.sensor = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b0) begin
        $display("FAIL glitch_high: edge %0d buzzer0 %b want 0", i, bus.buzzer[0]); n_fail++;
      end
      n_checks++;
    end
    bus.sensor = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b0 || bus.alarm_count !== 2'd0) begin
        $display("FAIL glitch_low: buzzer0 %b count %0d want 0/0",
                 bus.buzzer[0], bus.alarm_count); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_alarm_continuous();
    bus.pulse_mode = 1'b0;
    bus.sensor     = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b0) begin
        $display("FAIL debounce_wait: edge %0d buzzer0 %b want 0", i, bus.buzzer[0]); n_fail++;
      end
      n_checks++;
    end
    step();
    if (bus.buzzer !== 3'b001 || bus.alarm_active !== 3'b001) begin
      $display("FAIL alarm_rise: buzzer %b active %b want 001/001",
               bus.buzzer, bus.alarm_active); n_fail++;
    end
    n_checks++;
    if (bus.alarm_count !== 2'd1 || bus.any_alarm !== 1'b1) begin
      $display("FAIL alarm_status: count %0d any %b want 1/1", bus.alarm_count, bus.any_alarm);
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b1) begin
        $display("FAIL alarm_steady: buzzer0 %b want 1", bus.buzzer[0]); n_fail++;
      end
      n_checks++;
    end
    // Ack and sensor drop together: ack wins, so no hold period follows.
    bus.sensor = 3'b000;
    bus.ack    = 3'b001;
    step();
    bus.ack = 3'b000;
    if (bus.buzzer[0] !== 1'b0 || bus.alarm_active[0] !== 1'b0) begin
      $display("FAIL ack_over_drop: buzzer0 %b active0 %b want 0/0",
               bus.buzzer[0], bus.alarm_active[0]); n_fail++;
    end
    n_checks++;
    step();
    if (bus.buzzer[0] !== 1'b0 || bus.alarm_active[0] !== 1'b0) begin
      $display("FAIL silenced_to_idle: buzzer0 %b active0 %b want 0/0",
               bus.buzzer[0], bus.alarm_active[0]); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_pulse();
    logic [7:0] pat;
    pat            = 8'b1100_1100;
    bus.pulse_mode = 1'b1;
    bus.sensor     = 3'b001;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.buzzer[0] !== pat[7-i] || bus.alarm_active[0] !== 1'b1) begin
        $display("FAIL pulse_pattern: idx %0d buzzer0 %b active0 %b want %b/1",
                 i, bus.buzzer[0], bus.alarm_active[0], pat[7-i]); n_fail++;
      end
      n_checks++;
    end
    // Switching mode must not reset the phase.
    bus.pulse_mode = 1'b0;
    step();
    if (bus.buzzer[0] !== 1'b1) begin
      $display("FAIL mode_to_cont: buzzer0 %b want 1", bus.buzzer[0]); n_fail++;
    end
    n_checks++;
    bus.pulse_mode = 1'b1;
    step();
    if (bus.buzzer[0] !== 1'b1) begin
      $display("FAIL mode_back_a: buzzer0 %b want 1", bus.buzzer[0]); n_fail++;
    end
    n_checks++;
    step();
    if (bus.buzzer[0] !== 1'b0) begin
      $display("FAIL mode_back_b: buzzer0 %b want 0", bus.buzzer[0]); n_fail++;
    end
    n_checks++;
    bus.pulse_mode = 1'b0;
    go_idle();
  endtask

  task automatic test_hold();
    bus.pulse_mode = 1'b0;
    bus.sensor     = 3'b001;
    for (int i = 0; i < 5; i++) step();
    bus.sensor = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b1 || bus.alarm_active[0] !== 1'b1) begin
        $display("FAIL hold_sound: cycle %0d buzzer0 %b active0 %b want 1/1",
                 i, bus.buzzer[0], bus.alarm_active[0]); n_fail++;
      end
      n_checks++;
    end
    step();
    if (bus.buzzer[0] !== 1'b0 || bus.alarm_active[0] !== 1'b0 || bus.alarm_count !== 2'd0) begin
      $display("FAIL hold_expire: buzzer0 %b active0 %b count %0d want 0/0/0",
               bus.buzzer[0], bus.alarm_active[0], bus.alarm_count); n_fail++;
    end
    n_checks++;
    // Re-trigger from hold at hold_cnt=3.
    bus.sensor = 3'b001;
    for (int i = 0; i < 5; i++) step();
    bus.sensor = 3'b000;
    for (int i = 0; i < 4; i++) step();
    bus.sensor = 3'b001;
    step();
    if (bus.buzzer[0] !== 1'b1 || bus.alarm_active[0] !== 1'b1) begin
      $display("FAIL retrigger: buzzer0 %b active0 %b want 1/1",
               bus.buzzer[0], bus.alarm_active[0]); n_fail++;
    end
    n_checks++;
    // Back in alarm, so a fresh drop gets a full hold period.
    bus.sensor = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b1) begin
        $display("FAIL rehold_sound: cycle %0d buzzer0 %b want 1", i, bus.buzzer[0]); n_fail++;
      end
      n_checks++;
    end
    step();
    if (bus.buzzer[0] !== 1'b0) begin
      $display("FAIL rehold_expire: buzzer0 %b want 0", bus.buzzer[0]); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_ack();
    bus.sensor = 3'b001;
    for (int i = 0; i < 5; i++) step();
    bus.ack = 3'b001;
    step();
    bus.ack = 3'b000;
    if (bus.buzzer[0] !== 1'b0 || bus.alarm_active[0] !== 1'b0) begin
      $display("FAIL ack_silence: buzzer0 %b active0 %b want 0/0",
               bus.buzzer[0], bus.alarm_active[0]); n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b0) begin
        $display("FAIL silenced_stay: buzzer0 %b want 0", bus.buzzer[0]); n_fail++;
      end
      n_checks++;
    end
    bus.sensor = 3'b000;
    step();
    bus.sensor = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.buzzer[0] !== 1'b0) begin
        $display("FAIL rearm_debounce: edge %0d buzzer0 %b want 0", i, bus.buzzer[0]); n_fail++;
      end
      n_checks++;
    end
    step();
    if (bus.buzzer[0] !== 1'b1) begin
      $display("FAIL rearm_alarm: buzzer0 %b want 1", bus.buzzer[0]); n_fail++;
    end
    n_checks++;
    // Ack during hold returns straight to idle.
    bus.sensor = 3'b000;
    step();
    bus.ack = 3'b001;
    step();
    bus.ack = 3'b000;
    if (bus.buzzer[0] !== 1'b0 || bus.alarm_active[0] !== 1'b0) begin
      $display("FAIL ack_hold: buzzer0 %b active0 %b want 0/0",
               bus.buzzer[0], bus.alarm_active[0]); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_multi();
    bus.sensor = 3'b110;
    for (int i = 0; i < 4; i++) step();
    if (bus.buzzer !== 3'b000) begin
      $display("FAIL multi_wait: buzzer %b want 000", bus.buzzer); n_fail++;
    end
    n_checks++;
    step();
    if (bus.buzzer !== 3'b110 || bus.alarm_count !== 2'd2 || bus.any_alarm !== 1'b1) begin
      $display("FAIL multi_rise: buzzer %b count %0d any %b want 110/2/1",
               bus.buzzer, bus.alarm_count, bus.any_alarm); n_fail++;
    end
    n_checks++;
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.buzzer !== 3'b000 || bus.alarm_active !== 3'b000 || bus.alarm_count !== 2'd0) begin
        $display("FAIL disable: buzzer %b active %b count %0d want 000/000/0",
                 bus.buzzer, bus.alarm_active, bus.alarm_count); n_fail++;
      end
      n_checks++;
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    if (bus.buzzer !== 3'b000) begin
      $display("FAIL reenable_wait: buzzer %b want 000", bus.buzzer); n_fail++;
    end
    n_checks++;
    step();
    if (bus.buzzer !== 3'b110) begin
      $display("FAIL reenable_alarm: buzzer %b want 110", bus.buzzer); n_fail++;
    end
    n_checks++;
    #2 reset = 1'b0;
    #1;
    if (bus.buzzer !== 3'b000 || bus.alarm_active !== 3'b000 ||
        bus.alarm_count !== 2'd0 || bus.any_alarm !== 1'b0) begin
      $display("FAIL async_reset: buzzer %b active %b count %0d any %b want 000/000/0/0",
               bus.buzzer, bus.alarm_active, bus.alarm_count, bus.any_alarm); n_fail++;
    end
    n_checks++;
    #2 reset = 1'b1;
    go_idle();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.pulse_mode = 1'b0;
    bus.sensor     = 3'b000;
    bus.ack        = 3'b000;
    test_reset();
    test_glitch();
    test_alarm_continuous();
    test_pulse();
    test_hold();
    test_ack();
    test_multi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
